wb_sram_slave: RTL and testbench

- Wishbone B4 slave responder fronting an internal word-addressed SRAM.
- Attaches to one slave port of the team's Wishbone interconnects.
- Supports classic single cycles and registered-feedback bursts: incrementing via CTI/BTE with wrap, and constant-address.
- Returns ERR for addresses outside its window.

---
 rtl/wb_sram_slave.sv | 159 +++++++++++++++
 tb/tb_wb_sram_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave in front of a word-addressed SRAM: classic cycles,
// registered-feedback incrementing/constant bursts with BTE wrap, ERR outside the window.
module wb_sram_slave #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int unsigned NB    = WB_DATA_WIDTH / 8;
  localparam int unsigned BSH   = $clog2(NB);
  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR_RESP} state_t;

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  state_t                   state, state_n;
  logic                     ack_r, ack_n, err_r, err_n;
  logic [MEM_ADDR_BITS-1:0] cur, cur_n, adr_word, nxt, wrap_mask;
  logic [MEM_ADDR_BITS:0]   sum;
  logic [WB_DATA_WIDTH-1:0] dat_r, dat_n, rd_next;
  logic [WB_ADDR_WIDTH-1:0] offset;
  logic                     in_range, addr_hit, burst_miss, ack_out, wr_en;
  logic                     nxt_over, inc, burst_cti;

  assign offset   = ADR - BASE_ADDR;
  assign in_range = (ADR >= BASE_ADDR) && ((offset >> (BSH + MEM_ADDR_BITS)) == '0);
  assign adr_word = offset[BSH +: MEM_ADDR_BITS];

  // A strobed burst beat whose address differs from the prediction is not acked
  // in that cycle; the FSM falls back to IDLE and serves it as a fresh request.
  assign addr_hit   = in_range && (adr_word == cur);
  assign burst_miss = (state == BURST) && !addr_hit;
  assign ack_out    = ack_r && CYC && STB && !burst_miss;
  assign wr_en      = ack_out && WE;

  assign ACK   = ack_out;
  assign ERR   = err_r && CYC && STB;
  assign DAT_R = dat_r;

  assign burst_cti = (CTI == 3'b001) || (CTI == 3'b010);
  assign inc       = (CTI == 3'b010);

  always_comb begin
    case (BTE)
      2'b01:   wrap_mask = MEM_ADDR_BITS'(4'h3);
      2'b10:   wrap_mask = MEM_ADDR_BITS'(4'h7);
      2'b11:   wrap_mask = MEM_ADDR_BITS'(4'hF);
      default: wrap_mask = '1;
    endcase
    sum      = {1'b0, cur} + {{MEM_ADDR_BITS{1'b0}}, inc};
    nxt      = (cur & ~wrap_mask) | (sum[MEM_ADDR_BITS-1:0] & wrap_mask);
    nxt_over = (BTE == 2'b00) && sum[MEM_ADDR_BITS];
  end

  // Write-first: a beat writing the word about to be prefetched forwards its lanes.
  always_comb begin
    rd_next = mem[nxt];
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_en && (nxt == cur) && SEL[b]) rd_next[8*b +: 8] = DAT_W[8*b +: 8];
    end
  end

  always_comb begin
    state_n = state;
    ack_n   = ack_r;
    err_n   = err_r;
    cur_n   = cur;
    dat_n   = dat_r;
    if (!CYC) begin
      state_n = IDLE;
      ack_n   = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_n = 1'b0;
          err_n = 1'b0;
          if (STB) begin
            if (!in_range) begin
              err_n   = 1'b1;
              state_n = ERR_RESP;
            end else begin
              ack_n   = 1'b1;
              cur_n   = adr_word;
              dat_n   = mem[adr_word];
              state_n = burst_cti ? BURST : SINGLE;
            end
          end
        end
        SINGLE: begin
          if (STB) begin
            ack_n   = 1'b0;
            state_n = IDLE;
          end
        end
        ERR_RESP: begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
        BURST: begin
          if (STB) begin
            if (burst_miss || !burst_cti) begin
              ack_n   = 1'b0;
              state_n = IDLE;
            end else if (nxt_over) begin
              ack_n   = 1'b0;
              err_n   = 1'b1;
              state_n = ERR_RESP;
            end else begin
              cur_n = nxt;
              dat_n = rd_next;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      ack_r <= 1'b0;
      err_r <= 1'b0;
      cur   <= '0;
      dat_r <= '0;
    end else begin
      state <= state_n;
      ack_r <= ack_n;
      err_r <= err_n;
      cur   <= cur_n;
      dat_r <= dat_n;
    end
  end

  // Memory is not reset; a beat already acked on the reset edge still commits.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_en && SEL[b]) mem[cur][8*b +: 8] <= DAT_W[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: reference memory model plus a queue of
// expected read data, compared whenever the slave acknowledges a read beat.
module tb_wb_sram_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 10;
  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] ADR = '0;
  logic [2:0]  CTI = '0;
  logic [1:0]  BTE = '0;
  logic [31:0] DAT_W = '0;
  logic [31:0] DAT_R;
  logic        CYC = 1'b0;
  logic        STB = 1'b0;
  logic        WE = 1'b0;
  logic [3:0]  SEL = '0;
  logic        ACK;
  logic        ERR;

  always #5 clk = ~clk;

  wb_sram_slave #(
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .MEM_ADDR_BITS(MB),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rstn(rstn), .ADR(ADR), .CTI(CTI), .BTE(BTE),
    .DAT_W(DAT_W), .DAT_R(DAT_R), .CYC(CYC), .STB(STB), .WE(WE),
    .SEL(SEL), .ACK(ACK), .ERR(ERR)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] model [1024];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
  endtask

  // Starts at posedge+1, returns at posedge+4 with a response visible or the budget spent.
  task automatic wait_resp(output int waits);
    waits = 0;
    #3;
    while (!(ACK || ERR) && waits < 8) begin
      tick();
      waits++;
      #3;
    end
  endtask

  task automatic take_read(input string tag);
    if (exp_q.size() > 0) check(tag, DAT_R, exp_q.pop_front());
    else check({tag, "_q"}, 32'd0, 32'd1);
  endtask

  function automatic int unsigned bnext(input int unsigned w, input logic [2:0] cti,
                                        input logic [1:0] bte);
    int unsigned i;
    i = (cti == 3'b010) ? 1 : 0;
    case (bte)
      2'b01:   return (w & ~32'd3)  | ((w + i) & 32'd3);
      2'b10:   return (w & ~32'd7)  | ((w + i) & 32'd7);
      2'b11:   return (w & ~32'd15) | ((w + i) & 32'd15);
      default: return w + i;
    endcase
  endfunction

  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic exp_err, input string tag);
    int unsigned w;
    int waits;
    w = ((adr - BASE) >> 2) & 32'h3FF;
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_W = dat; SEL = sel;
    CTI = 3'b000; BTE = 2'b00;
    if (!we && !exp_err) exp_q.push_back(model[w]);
    wait_resp(waits);
    check({tag, "_lat"}, 32'(waits), 32'd1);
    check({tag, "_ack"}, 32'(ACK), 32'(!exp_err));
    check({tag, "_err"}, 32'(ERR), 32'(exp_err));
    if (ACK && !we) take_read(tag);
    if (ACK && we) model_write(w, dat, sel);
    tick();
    if (exp_err) begin
      #3;
      check({tag, "_err_once"}, 32'(ERR), 32'd0);
      tick();
    end
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    tick();
    tick();
  endtask

  task automatic burst(input logic [31:0] wemask, input int unsigned start, input logic [2:0] cti,
                       input logic [1:0] bte, input int n, input int gap_after,
                       input int err_beat, input logic [31:0] dbase, input string tag);
    int unsigned w;
    int waits;
    bit stop;
    w = start;
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) begin
      CYC = 1'b1; STB = 1'b1; WE = wemask[i]; ADR = BASE + w * 4;
      CTI = (i == n - 1) ? 3'b111 : cti; BTE = bte; DAT_W = dbase + i; SEL = 4'hF;
      if (i == err_beat) begin
        wait_resp(waits);
        check({tag, "_errlat"}, 32'(waits), 32'd0);
        check({tag, "_errbeat"}, 32'(ERR), 32'd1);
        check({tag, "_errnoack"}, 32'(ACK), 32'd0);
        stop = 1'b1;
        tick();
      end else begin
        if (!WE) exp_q.push_back(model[w]);
        wait_resp(waits);
        check($sformatf("%s_lat%0d", tag, i), 32'(waits), (i == 0) ? 32'd1 : 32'd0);
        if (ACK && !WE) take_read($sformatf("%s_rd%0d", tag, i));
        if (ACK && WE) model_write(w, DAT_W, SEL);
        tick();
        if (i == gap_after) begin
          STB = 1'b0;
          for (int g = 0; g < 2; g++) begin
            #3;
            check($sformatf("%s_gap%0d", tag, g), 32'(ACK), 32'd0);
            tick();
          end
        end
        w = bnext(w, cti, bte);
      end
    end
    if (!stop) begin
      // Present the would-be next beat: a terminated burst must not ack it.
      STB = 1'b1; WE = 1'b0; CTI = cti; ADR = BASE + w * 4;
      #3;
      check({tag, "_end"}, 32'(ACK), 32'd0);
      tick();
    end
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with a request pending so ACK/ERR gating is exercised.
    rstn = 1'b0; CYC = 1'b1; STB = 1'b1; ADR = BASE;
    repeat (3) tick();
    #3;
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_dat", DAT_R, 32'd0);
    tick();
    CYC = 1'b0; STB = 1'b0; rstn = 1'b1;
    tick();

    // Classic write then read back.
    classic(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "cl_wr");
    classic(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, "cl_rd");

    // Partial byte-lane write.
    classic(1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 1'b0, "sel_pre");
    classic(1'b1, BASE + 32'h20, 32'h0000AB00, 4'b0010, 1'b0, "sel_wr");
    classic(1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, "sel_rd");

    // Wrap-4 incrementing read burst from word 3.
    for (int i = 0; i < 4; i++) classic(1'b1, BASE + i * 4, i, 4'hF, 1'b0, "pre");
    burst(32'h0, 3, 3'b010, 2'b01, 4, -1, -1, 32'h0, "w4rd");

    // Linear write burst with a two-cycle master wait state.
    classic(1'b1, BASE + 32'h10, 32'h44444444, 4'hF, 1'b0, "pre4");
    burst(32'hF, 0, 3'b010, 2'b00, 4, 1, -1, 32'hA5A50000, "linwr");
    for (int i = 0; i < 5; i++) classic(1'b0, BASE + i * 4, 32'h0, 4'hF, 1'b0, $sformatf("lin_rb%0d", i));

    // Out-of-window write, then a normal access.
    classic(1'b1, BASE + (32'd4 << MB), 32'hBAD0BAD0, 4'hF, 1'b1, "oow");
    classic(1'b0, BASE, 32'h0, 4'hF, 1'b0, "oow_rb");

    // Constant-address burst: write then read returns the new data.
    classic(1'b1, BASE + 20 * 4, 32'h55555555, 4'hF, 1'b0, "pre20");
    burst(32'h1, 20, 3'b001, 2'b00, 2, -1, -1, 32'hC0DE0000, "const");

    // Linear burst running off the top of the window.
    burst(32'hF, 1022, 3'b010, 2'b00, 3, -1, 2, 32'h7E570000, "top");
    classic(1'b0, BASE + 1022 * 4, 32'h0, 4'hF, 1'b0, "top_rb0");
    classic(1'b0, BASE + 1023 * 4, 32'h0, 4'hF, 1'b0, "top_rb1");
    classic(1'b0, BASE, 32'h0, 4'hF, 1'b0, "top_rb2");

    // Reset asserted during beat 2 of a write burst.
    for (int i = 8; i < 12; i++) classic(1'b1, BASE + i * 4, 32'h0F0F0000 + i, 4'hF, 1'b0, "pre8");
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; CTI = 3'b010; BTE = 2'b00; SEL = 4'hF;
    ADR = BASE + 8 * 4; DAT_W = 32'hB0000001;
    #3;
    check("rb_b1_wait", 32'(ACK), 32'd0);
    tick();
    #3;
    check("rb_b1_ack", 32'(ACK), 32'd1);
    model_write(8, DAT_W, SEL);
    tick();
    ADR = BASE + 9 * 4; DAT_W = 32'hB0000002;
    #3;
    check("rb_b2_ack", 32'(ACK), 32'd1);
    model_write(9, DAT_W, SEL);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    ADR = BASE + 10 * 4; DAT_W = 32'hB0000003;
    #3;
    check("rb_after_rst", 32'(ACK), 32'd0);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    tick();
    tick();
    for (int i = 8; i < 12; i++) classic(1'b0, BASE + i * 4, 32'h0, 4'hF, 1'b0, $sformatf("rb_rd%0d", i));

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
